// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types, width helpers and reset constants for the IF layer scheduler
package if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic NRST_INIT = 1'b1;

    function automatic int cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/if_refrac_counter.sv
// rtl/if_refrac_counter.sv - per-neuron refractory down-counter driving one neuron reset bit
module if_refrac_counter
    import if_pkg::*;
#(
    parameter int REFRAC = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic spike,
    output logic accept,
    output logic neuron_rst
);

    localparam int RC_W = $clog2(REFRAC + 2);

    logic [RC_W-1:0] r_cnt;
    logic            r_rst;

    // Refractory is tracked by the counter, not r_rst, since r_rst is forced high outside RUN.
    assign accept     = en && spike && (r_cnt == '0);
    assign neuron_rst = r_rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_rst <= NRST_INIT;
        end else if (clear) begin
            r_cnt <= '0;
            r_rst <= NRST_INIT;
        end else if (accept) begin
            r_cnt <= RC_W'(REFRAC + 1);
            r_rst <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - RC_W'(1);
            r_rst <= (r_cnt > RC_W'(1));
        end else begin
            r_rst <= 1'b0;
        end
    end

endmodule

// File: rtl/if_layer_scheduler.sv
// rtl/if_layer_scheduler.sv - windowed IF layer sequencer with refractory hold and spike-count winner
// IF_SPIKE_COUNT_EN: when defined, per-neuron spike counters and winner selection are built.
module if_layer_scheduler
    import if_pkg::*;
#(
    parameter  int REFRAC      = 5,
    parameter  int NUM_OUTPUTS = 4,
    parameter  int NUM_STEPS   = 16,
    localparam int CNT_W       = cnt_width(NUM_STEPS),
    localparam int IDX_W       = idx_width(NUM_OUTPUTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_OUTPUTS-1:0]       spike_in,
    output logic [NUM_OUTPUTS-1:0]       neuron_rst,
    output logic                         neuron_en,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             step_cnt,
    output logic [NUM_OUTPUTS*CNT_W-1:0] spike_cnt,
    output logic [IDX_W-1:0]             winner,
    output logic                         winner_valid
);

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_W-1:0]         r_step;
    logic                     r_neuron_en;
    logic                     w_start;
    logic                     w_clear;
    logic [NUM_OUTPUTS-1:0]   w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (r_step == CNT_W'(NUM_STEPS - 1)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_start = (r_state == ST_IDLE) && start;
    // Driven from next state so neuron_rst is a plain register that already reads all-ones in DONE/IDLE.
    assign w_clear = (w_next != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step      <= '0;
            r_neuron_en <= 1'b0;
        end else begin
            r_neuron_en <= (w_next == ST_RUN);
            if (w_start)                 r_step <= '0;
            else if (r_state == ST_RUN)  r_step <= r_step + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_neuron
        if_refrac_counter #(.REFRAC(REFRAC)) u_refrac (
            .clk        (clk),
            .rst        (rst),
            .clear      (w_clear),
            .en         (r_state == ST_RUN),
            .spike      (spike_in[i]),
            .accept     (w_accept[i]),
            .neuron_rst (neuron_rst[i])
        );
    end

    assign neuron_en = r_neuron_en;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign step_cnt  = r_step;

`ifdef IF_SPIKE_COUNT_EN
    logic [CNT_W-1:0] r_cnt [NUM_OUTPUTS];
    logic [CNT_W-1:0] w_best_cnt;
    logic [IDX_W-1:0] w_best_idx;
    logic [IDX_W-1:0] r_winner;
    logic             r_winner_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_start) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUTPUTS; i++)
                if (w_accept[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_best_cnt = '0;
        w_best_idx = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (r_cnt[i] > w_best_cnt) begin
                w_best_cnt = r_cnt[i];
                w_best_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
        end else if (w_start) begin
            r_winner_valid <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_winner       <= w_best_idx;
            r_winner_valid <= (w_best_cnt != '0);
        end
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt_out
        assign spike_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
`else
    logic w_unused_accept;
    assign w_unused_accept = ^w_accept;
    assign spike_cnt       = '0;
    assign winner          = '0;
    assign winner_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_if_layer_scheduler.sv
// tb/tb_if_layer_scheduler.sv - directed table-driven bench for if_layer_scheduler
module tb_if_layer_scheduler;

`ifdef IF_SPIKE_COUNT_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif
    localparam int N  = 4;
    localparam int S  = 10;
    localparam int CW = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          a_start = 1'b0, b_start = 1'b0;
    logic [N-1:0]  a_spike = '0,   b_spike = '0;
    logic [N-1:0]  a_rst, b_rst;
    logic          a_en, b_en, a_busy, b_busy, a_done, b_done;
    logic [CW-1:0] a_step, b_step;
    logic [N*CW-1:0] a_cnt, b_cnt;
    logic [IW-1:0] a_win, b_win;
    logic          a_val, b_val;

    if_layer_scheduler #(.REFRAC(2), .NUM_OUTPUTS(N), .NUM_STEPS(S)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .spike_in(a_spike),
        .neuron_rst(a_rst), .neuron_en(a_en), .busy(a_busy), .done(a_done),
        .step_cnt(a_step), .spike_cnt(a_cnt), .winner(a_win), .winner_valid(a_val)
    );

    if_layer_scheduler #(.REFRAC(0), .NUM_OUTPUTS(N), .NUM_STEPS(S)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .spike_in(b_spike),
        .neuron_rst(b_rst), .neuron_en(b_en), .busy(b_busy), .done(b_done),
        .step_cnt(b_step), .spike_cnt(b_cnt), .winner(b_win), .winner_valid(b_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] spike;
        logic [3:0] e_rst;
        logic       e_en;
        logic       e_busy;
        logic       e_done;
        int         e_step;
    } vec_t;

    vec_t tbl [12];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [3:0] sp, input logic [3:0] r,
                                input logic en, input logic bz, input logic dn, input int stp);
        vec_t v;
        v.start = st; v.spike = sp; v.e_rst = r; v.e_en = en;
        v.e_busy = bz; v.e_done = dn; v.e_step = stp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_counts(input string nm, input int c0, input int c1, input int c2,
                                input int c3, input int w, input int val);
        chk({nm, "_cnt0"}, int'(a_cnt[0*CW +: CW]), CE * c0);
        chk({nm, "_cnt1"}, int'(a_cnt[1*CW +: CW]), CE * c1);
        chk({nm, "_cnt2"}, int'(a_cnt[2*CW +: CW]), CE * c2);
        chk({nm, "_cnt3"}, int'(a_cnt[3*CW +: CW]), CE * c3);
        chk({nm, "_winner"}, int'(a_win), CE * w);
        chk({nm, "_valid"}, int'(a_val), CE * val);
    endtask

    initial begin
        int n;
        bit seen;

        // Neuron 1 held high with REFRAC=2: accepts at steps 0, 4, 8; starts in RUN/DONE ignored.
        tbl[0]  = mk(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 0);
        tbl[1]  = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 1);
        tbl[2]  = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 2);
        tbl[3]  = mk(1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 3);
        tbl[4]  = mk(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 4);
        tbl[5]  = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 5);
        tbl[6]  = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 6);
        tbl[7]  = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 7);
        tbl[8]  = mk(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 8);
        tbl[9]  = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 9);
        tbl[10] = mk(1'b1, 4'b0010, 4'b1111, 1'b0, 1'b1, 1'b1, 10);
        tbl[11] = mk(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 10);

        #12;
        chk("rst_nrst",  int'(a_rst),  15);
        chk("rst_en",    int'(a_en),   0);
        chk("rst_busy",  int'(a_busy), 0);
        chk("rst_done",  int'(a_done), 0);
        chk("rst_step",  int'(a_step), 0);
        chk("rst_cnt",   int'(a_cnt == '0), 1);
        chk("rst_win",   int'(a_win),  0);
        chk("rst_val",   int'(a_val),  0);
        #5 rst = 1'b0;
        tick();
        chk("idle_nrst",   int'(a_rst),  15);
        chk("idle_en",     int'(a_en),   0);
        chk("idle_busy",   int'(a_busy), 0);
        chk("idle_b_nrst", int'(b_rst),  15);
        chk("idle_b_busy", int'(b_busy), 0);

        for (int j = 0; j < 12; j++) begin
            a_start = tbl[j].start;
            a_spike = tbl[j].spike;
            tick();
            chk($sformatf("tbl%0d_nrst", j), int'(a_rst),  int'(tbl[j].e_rst));
            chk($sformatf("tbl%0d_en", j),   int'(a_en),   int'(tbl[j].e_en));
            chk($sformatf("tbl%0d_busy", j), int'(a_busy), int'(tbl[j].e_busy));
            chk($sformatf("tbl%0d_done", j), int'(a_done), int'(tbl[j].e_done));
            chk($sformatf("tbl%0d_step", j), int'(a_step), tbl[j].e_step);
        end
        a_start = 1'b0;
        a_spike = '0;
        chk_a_counts("hold", 0, 3, 0, 0, 1, 1);

        // REFRAC=0: a single spike at step 4 resets neuron 0 only during step 5.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int s = 0; s < S; s++) begin
            chk($sformatf("b_step%0d", s), int'(b_step), s);
            chk($sformatf("b_en%0d", s), int'(b_en), 1);
            chk($sformatf("b_nrst0_s%0d", s), int'(b_rst[0]), (s == 5) ? 1 : 0);
            b_spike = (s == 4) ? 4'b0001 : 4'b0000;
            tick();
        end
        b_spike = '0;
        chk("b_done", int'(b_done), 1);
        tick();
        chk("b_cnt0",  int'(b_cnt[0 +: CW]), CE * 1);
        chk("b_win",   int'(b_win), 0);
        chk("b_valid", int'(b_val), CE * 1);

        // Neurons 2 and 3 tie at 3 spikes: done latency and lowest-index winner.
        a_start = 1'b1;
        a_spike = 4'b1100;
        n = 0;
        do begin
            tick();
            a_start = 1'b0;
            n++;
        end while (!a_done && n < 30);
        chk("tie_done_lat", n, 11);
        a_spike = '0;
        tick();
        chk("tie_done_drop", int'(a_done), 0);
        chk_a_counts("tie", 0, 0, 3, 3, 2, 1);

        // Empty window: winner falls back to 0, invalid.
        a_start = 1'b1;
        n = 0;
        do begin
            tick();
            a_start = 1'b0;
            n++;
        end while (!a_done && n < 30);
        chk("empty_done_lat", n, 11);
        tick();
        chk_a_counts("empty", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset at step 5 after two accepted spikes on neuron 0.
        a_start = 1'b1;
        a_spike = 4'b0001;
        n = 0;
        do begin
            tick();
            a_start = 1'b0;
            n++;
        end while (int'(a_step) != 5 && n < 30);
        chk("abort_reach_step5", int'(a_step), 5);
        chk("abort_pre_cnt0", int'(a_cnt[0 +: CW]), CE * 2);
        #2 rst = 1'b1;
        #1;
        chk("abort_nrst", int'(a_rst),  15);
        chk("abort_en",   int'(a_en),   0);
        chk("abort_busy", int'(a_busy), 0);
        chk("abort_done", int'(a_done), 0);
        chk("abort_step", int'(a_step), 0);
        chk_a_counts("abort", 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        a_spike = '0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (a_done) seen = 1'b1;
        end
        chk("abort_no_done", int'(seen), 0);
        chk("abort_idle_busy", int'(a_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_layer_scheduler.md
# if_layer_scheduler

Sequences one integrate-and-fire layer through a fixed-length presentation window. It gates the layer with a per-timestep enable and enforces a per-neuron refractory period by holding spiking neurons in reset for REFRAC+1 cycles. It also counts accepted output spikes per neuron and reports the winning neuron at the end of the window. It sits between the top-level run control and the IF neuron array, driving the neurons' `rst` and enable inputs.

## Interface
- `REFRAC`, default 5: number of extra cycles a neuron is held in reset after an accepted spike. 0 is legal.
- `NUM_OUTPUTS`, default 4: number of neurons in the layer. Must be ≥ 1.
- `NUM_STEPS`, default 16: timesteps per presentation window. Must be ≥ 1.
- `CNT_W`: derived, equal to $clog2(NUM_STEPS+1). Not user-set.
- `IDX_W`: derived, equal to max(1, $clog2(NUM_OUTPUTS)).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  starts a window; sampled only in IDLE.
- `spike_in`  in  NUM_OUTPUTS  spike outputs of the neurons, one bit per neuron.
- `neuron_rst`  out  NUM_OUTPUTS  per-neuron reset, registered.
- `neuron_en`  out  1  timestep enable to the neuron array, registered.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse at the end of a window.
- `step_cnt`  out  CNT_W  current timestep index.
- `spike_cnt`  out  NUM_OUTPUTS*CNT_W  flattened per-neuron spike counts; neuron i occupies bits [i*CNT_W +: CNT_W].
- `winner`  out  IDX_W  index of the neuron with the most spikes.
- `winner_valid`  out  1  high when `winner` holds a valid result.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `neuron_rst` is all-ones and `neuron_en` is 0.
  - `start`=1 causes a transition to RUN.
  - On that transition, clear `step_cnt`, all refractory counters, all `spike_cnt` and `winner_valid`.
- RUN:
  - `neuron_en` is 1. Each RUN cycle is one timestep.
  - `spike_in[i]` is accepted when it is 1 and neuron i is not refractory.
  - An accepted spike increments `spike_cnt[i]` and starts a refractory window.
  - A refractory window drives `neuron_rst[i]`=1 for exactly REFRAC+1 cycles, starting the next cycle.
  - While neuron i is refractory, `spike_in[i]` is ignored: it is neither counted nor re-arms the window.
  - `step_cnt` increments each cycle. The cycle with `step_cnt`=NUM_STEPS-1 is the last timestep; the next state is DONE.
- DONE (exactly 1 cycle):
  - `neuron_rst` is all-ones, `neuron_en`=0, `done`=1.
  - `winner` is latched as the lowest index holding the maximum count.
  - `winner_valid` is set to 1 if that maximum is greater than 0.
  - The next state is IDLE.
- Counts, `winner` and `winner_valid` hold until the next accepted `start`.
- `start` is ignored in RUN and DONE.
- Counts cannot overflow: the maximum possible value is NUM_STEPS, which fits in CNT_W bits.
- Refractory windows still open at the end of RUN are cleared; all neurons are in reset in DONE anyway.

## Timing
- Reset values: `neuron_rst`=all-ones, `neuron_en`=0, `busy`=0, `done`=0, `step_cnt`=0, `spike_cnt`=0, `winner`=0, `winner_valid`=0. State resets to IDLE.
- Reset asserted mid-window aborts immediately to IDLE. No `done` is produced.
- Cycle T samples `start`=1 in IDLE. Then `neuron_en`=1 from T+1 through T+NUM_STEPS, `done`=1 at T+NUM_STEPS+1, and IDLE at T+NUM_STEPS+2.
- Spike latency: an accepted spike sampled at cycle t drives `neuron_rst[i]` high during cycles t+1 through t+1+REFRAC.
- A spike on the final RUN cycle is counted and included in `winner`.
- Multiple neurons spiking in the same cycle are handled independently.

## Configuration
- `IF_SPIKE_COUNT_EN` defined: spike counters and winner logic are present as described above.
- `IF_SPIKE_COUNT_EN` undefined: counters and winner logic are removed. `spike_cnt`, `winner` and `winner_valid` are tied to 0. Sequencing and refractory behaviour are unchanged.

## Structure
- Package `if_pkg` holds:
  - the FSM state enum (IDLE/RUN/DONE);
  - the width helper function for CNT_W and IDX_W;
  - the reset value constant for `neuron_rst`.
- Sub-module `if_refrac_counter`, one instance per neuron. Inputs: `clk`, `rst`, `clear`, `en`, `spike`. Outputs: `accept` and the registered `neuron_rst` bit. Each instance contains a down-counter of width $clog2(REFRAC+2).
- Winner selection is a combinational max-scan over the registered counts, with its result latched in DONE.

## Test plan
- Reset then idle, with NUM_OUTPUTS=4 → `neuron_rst`=4'b1111, `neuron_en`=0, `busy`=0. `start` pulsed while busy is ignored.
- REFRAC=2, `spike_in[1]` held at 1 for the whole run → `neuron_rst[1]` shows a 3-cycle high, then 1 cycle where a spike is accepted, repeating. With NUM_STEPS=10, `spike_cnt[1]`=3.
- REFRAC=0, single spike on neuron 0 at step 4 → `neuron_rst[0]` high for exactly one cycle at step 5, and `spike_cnt[0]`=1.
- NUM_STEPS=10, neurons 2 and 3 each accept 3 spikes → `done` asserts 11 cycles after `start`, `winner`=2, `winner_valid`=1.
- No spikes in the window → `done` pulses, `winner_valid`=0, `winner`=0.
- `rst` asserted at step 5 with `spike_cnt[0]`=2 → all outputs return to reset values immediately, and `done` never pulses.
